// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-pass 0..7 logical right shift controller for the 4-bit shift_right unit
module shift_sequencer #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [AMT_W-1:0] amt_in,
  output logic [WIDTH-1:0] sh_a,
  output logic [1:0]       sh_b,
  input  logic [WIDTH-1:0] sh_y,
  input  logic             sh_c,
  output logic [WIDTH-1:0] result,
  output logic             N,
  output logic             Z,
  output logic             C,
  output logic             V,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   work;
  logic [AMT_W-1:0]   rem;
  logic               c_acc;
  logic [1:0]         step;
  logic [AMT_W-1:0]   rem_left;
  logic               accept;

  // The shifter handles at most 3 positions per pass.
  assign step     = (rem > AMT_W'(3)) ? 2'd3 : rem[1:0];
  assign rem_left = rem - {{(AMT_W-2){1'b0}}, step};
  assign accept   = start_valid && start_ready && !rst;

  always_comb begin
    state_nxt   = state;
    start_ready = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    sh_a        = work;
    sh_b        = 2'd0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (accept)
          state_nxt = (amt_in == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        sh_b = step;
        if (rem_left == '0)
          state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      work   <= '0;
      rem    <= '0;
      c_acc  <= 1'b0;
      result <= '0;
      N      <= 1'b0;
      Z      <= 1'b0;
      C      <= 1'b0;
      V      <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            work  <= a_in;
            rem   <= amt_in;
            c_acc <= 1'b0;
          end
        end
        SHIFT: begin
          work  <= sh_y;
          rem   <= rem_left;
          c_acc <= sh_c;
        end
        DONE: begin
          result <= work;
          N      <= work[WIDTH-1];
          Z      <= (work == '0);
          C      <= c_acc;
          V      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - directed self-checking bench for shift_sequencer with a behavioural shifter
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_valid = 1'b0;
  logic       start_ready;
  logic [3:0] a_in = '0;
  logic [2:0] amt_in = '0;
  logic [3:0] sh_a;
  logic [1:0] sh_b;
  logic [3:0] sh_y;
  logic       sh_c;
  logic [3:0] result;
  logic       N, Z, C, V;
  logic       busy, done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Stand-in for the lab shift_right unit: logical shift, C is the last bit shifted out.
  always_comb begin
    sh_y = sh_a >> sh_b;
    sh_c = 1'b0;
    case (sh_b)
      2'd1: sh_c = sh_a[0];
      2'd2: sh_c = sh_a[1];
      2'd3: sh_c = sh_a[2];
      default: sh_c = 1'b0;
    endcase
  end

  shift_sequencer #(.WIDTH(4), .AMT_W(3)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .a_in(a_in), .amt_in(amt_in), .sh_a(sh_a), .sh_b(sh_b), .sh_y(sh_y), .sh_c(sh_c),
    .result(result), .N(N), .Z(Z), .C(C), .V(V), .busy(busy), .done(done)
  );

  // Issues one request from an IDLE negedge; returns latency in cycles from the
  // acceptance edge to the done cycle (-1 on timeout), the sh_b pass sequence,
  // and the number of busy cycles. Returns at the negedge of the done cycle.
  task automatic drive_op(input logic [3:0] a, input logic [2:0] amt,
                          output int lat, output logic [7:0] seq, output int nseq,
                          output int nbusy);
    lat = -1; seq = '0; nseq = 0; nbusy = 0;
    a_in = a; amt_in = amt; start_valid = 1'b1;
    @(posedge clk);
    #1 start_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (busy && !done && nseq < 4) begin
        seq[2*nseq +: 2] = sh_b;
        nseq++;
      end
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_valid = 1'b1; a_in = 4'b1111; amt_in = 3'd2;
    repeat (2) @(negedge clk);
    checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", start_ready); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got=%b%b exp=00", busy, done); end
    checks++; if (result !== 4'b0000) begin errors++; $display("FAIL reset_result got=%b exp=0000", result); end
    checks++; if ({N, Z, C, V} !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {N, Z, C, V}); end
    checks++; if (sh_b !== 2'd0 || sh_a !== 4'b0000) begin errors++; $display("FAIL reset_shifter got=%b/%0d exp=0000/0", sh_a, sh_b); end
    start_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_amt1();
    int lat, nseq, nbusy; logic [7:0] seq;
    drive_op(4'b1011, 3'd1, lat, seq, nseq, nbusy);
    checks++; if (lat !== 2) begin errors++; $display("FAIL amt1_latency got=%0d exp=2", lat); end
    checks++; if (nseq !== 1 || seq !== 8'h01) begin errors++; $display("FAIL amt1_seq got=%0d/%h exp=1/01", nseq, seq); end
    checks++; if (start_ready !== 1'b0) begin errors++; $display("FAIL amt1_ready_in_done got=%b exp=0", start_ready); end
    @(negedge clk);
    checks++; if (result !== 4'b0101) begin errors++; $display("FAIL amt1_result got=%b exp=0101", result); end
    checks++; if ({N, Z, C, V} !== 4'b0010) begin errors++; $display("FAIL amt1_flags got=%b exp=0010", {N, Z, C, V}); end
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL amt1_after got=%b%b exp=00", done, busy); end
  endtask

  task automatic test_amt7();
    int lat, nseq, nbusy; logic [7:0] seq;
    drive_op(4'b1011, 3'd7, lat, seq, nseq, nbusy);
    checks++; if (lat !== 4) begin errors++; $display("FAIL amt7_latency got=%0d exp=4", lat); end
    checks++; if (nseq !== 3 || seq !== 8'h1F) begin errors++; $display("FAIL amt7_seq got=%0d/%h exp=3/1f", nseq, seq); end
    checks++; if (nbusy !== 4) begin errors++; $display("FAIL amt7_busy got=%0d exp=4", nbusy); end
    @(negedge clk);
    checks++; if (result !== 4'b0000) begin errors++; $display("FAIL amt7_result got=%b exp=0000", result); end
    checks++; if ({N, Z, C, V} !== 4'b0100) begin errors++; $display("FAIL amt7_flags got=%b exp=0100", {N, Z, C, V}); end
  endtask

  task automatic test_amt4();
    int lat, nseq, nbusy; logic [7:0] seq;
    drive_op(4'b1000, 3'd4, lat, seq, nseq, nbusy);
    checks++; if (lat !== 3) begin errors++; $display("FAIL amt4_latency got=%0d exp=3", lat); end
    checks++; if (nseq !== 2 || seq !== 8'h07) begin errors++; $display("FAIL amt4_seq got=%0d/%h exp=2/07", nseq, seq); end
    @(negedge clk);
    checks++; if (result !== 4'b0000) begin errors++; $display("FAIL amt4_result got=%b exp=0000", result); end
    checks++; if ({N, Z, C, V} !== 4'b0110) begin errors++; $display("FAIL amt4_flags got=%b exp=0110", {N, Z, C, V}); end
  endtask

  task automatic test_amt0();
    int lat, nseq, nbusy; logic [7:0] seq;
    drive_op(4'b1000, 3'd0, lat, seq, nseq, nbusy);
    checks++; if (lat !== 1) begin errors++; $display("FAIL amt0_latency got=%0d exp=1", lat); end
    checks++; if (nseq !== 0) begin errors++; $display("FAIL amt0_no_shift got=%0d exp=0", nseq); end
    @(negedge clk);
    checks++; if (result !== 4'b1000) begin errors++; $display("FAIL amt0_result got=%b exp=1000", result); end
    checks++; if ({N, Z, C, V} !== 4'b1000) begin errors++; $display("FAIL amt0_flags got=%b exp=1000", {N, Z, C, V}); end
  endtask

  task automatic test_back_to_back();
    a_in = 4'b1011; amt_in = 3'd6; start_valid = 1'b1;
    @(posedge clk);
    #1 a_in = 4'b0101; amt_in = 3'd1;
    @(negedge clk);
    checks++; if (busy !== 1'b1 || sh_b !== 2'd3) begin errors++; $display("FAIL b2b_pass1 got=%b/%0d exp=1/3", busy, sh_b); end
    @(negedge clk);
    checks++; if (sh_b !== 2'd3 || done !== 1'b0) begin errors++; $display("FAIL b2b_pass2 got=%0d/%b exp=3/0", sh_b, done); end
    @(negedge clk);
    checks++; if (done !== 1'b1 || start_ready !== 1'b0) begin errors++; $display("FAIL b2b_done_not_ready got=%b%b exp=10", done, start_ready); end
    @(negedge clk);
    checks++; if (start_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%b%b exp=10", start_ready, busy); end
    checks++; if (result !== 4'b0000 || {N, Z, C, V} !== 4'b0100) begin errors++; $display("FAIL b2b_first_result got=%b/%b exp=0000/0100", result, {N, Z, C, V}); end
    @(posedge clk);
    #1 start_valid = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1 || sh_b !== 2'd1 || sh_a !== 4'b0101) begin errors++; $display("FAIL b2b_second_pass got=%b/%0d/%b exp=1/1/0101", busy, sh_b, sh_a); end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_second_done got=%b exp=1", done); end
    @(negedge clk);
    checks++; if (result !== 4'b0010 || {N, Z, C, V} !== 4'b0010) begin errors++; $display("FAIL b2b_second_result got=%b/%b exp=0010/0010", result, {N, Z, C, V}); end
  endtask

  task automatic test_reset_mid();
    int lat, nseq, nbusy, seen_done; logic [7:0] seq;
    seen_done = 0;
    a_in = 4'b1111; amt_in = 3'd7; start_valid = 1'b1;
    @(posedge clk);
    #1 start_valid = 1'b0;
    @(negedge clk);
    if (done) seen_done++;
    @(negedge clk);
    if (done) seen_done++;
    checks++; if (busy !== 1'b1 || sh_b !== 2'd3) begin errors++; $display("FAIL rstmid_in_shift got=%b/%0d exp=1/3", busy, sh_b); end
    rst = 1'b1; start_valid = 1'b1;
    @(negedge clk);
    if (done) seen_done++;
    checks++; if (start_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_state got=%b%b exp=10", start_ready, busy); end
    checks++; if (result !== 4'b0000 || {N, Z, C, V} !== 4'b0000) begin errors++; $display("FAIL rstmid_outputs got=%b/%b exp=0000/0000", result, {N, Z, C, V}); end
    rst = 1'b0; start_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    checks++; if (seen_done !== 0) begin errors++; $display("FAIL rstmid_no_done got=%0d exp=0", seen_done); end
    drive_op(4'b1011, 3'd1, lat, seq, nseq, nbusy);
    checks++; if (lat !== 2) begin errors++; $display("FAIL rstmid_recover_latency got=%0d exp=2", lat); end
    @(negedge clk);
    checks++; if (result !== 4'b0101 || {N, Z, C, V} !== 4'b0010) begin errors++; $display("FAIL rstmid_recover_result got=%b/%b exp=0101/0010", result, {N, Z, C, V}); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_amt1();
    test_amt7();
    test_amt4();
    test_amt0();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle controller that drives the lab's 4-bit `shift_right` unit to perform logical right shifts of 0–7 positions, although the unit handles only 0–3 positions per pass. It accepts an operand and shift amount through a valid/ready handshake and issues successive passes of at most 3 positions. It then registers the final result with N/Z/C/V flags in the same convention as the ALU flag outputs. It sits between the ALU operation decoder and a single `shift_right` instance, which it owns exclusively.

## Interface
- `WIDTH`, 4: operand width. Only 4 is supported, matching the shifter.
- `AMT_W`, 3: shift-amount width; total shift range is 0 to 2^AMT_W−1.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset. Single clock domain.
- `start_valid`  in  1  request strobe.
- `start_ready`  out  1  high exactly when state is IDLE.
- `a_in`  in  WIDTH  operand, sampled only on acceptance.
- `amt_in`  in  AMT_W  total shift amount, sampled only on acceptance.
- `sh_a`  out  WIDTH  drives the shifter's `a`.
- `sh_b`  out  2  drives the shifter's `b` (per-pass amount).
- `sh_y`  in  WIDTH  shifter's `y`.
- `sh_c`  in  1  shifter's `C` (last bit shifted out).
- `result`  out  WIDTH  registered shifted value.
- `N`, `Z`, `C`, `V`  out  1 each  registered flags.
- `busy`  out  1  high in SHIFT or DONE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States are IDLE, SHIFT, and DONE. Internal registers: `work[WIDTH-1:0]`, `rem[AMT_W-1:0]`, `c_acc`.
- IDLE:
  - Acceptance is `start_valid && start_ready && !rst`.
  - On acceptance: `work<=a_in`, `rem<=amt_in`, `c_acc<=0`.
  - Next state is DONE if `amt_in==0`, otherwise SHIFT.
- SHIFT, each cycle:
  - `step = (rem>3) ? 3 : rem[1:0]`.
  - Drive `sh_a=work`, `sh_b=step`.
  - Update `work<=sh_y`, `rem<=rem-step`, `c_acc<=sh_c`.
  - Go to DONE when `rem-step==0`; otherwise stay in SHIFT.
- DONE (exactly one cycle):
  - `done=1`.
  - `result<=work`, `N<=work[3]`, `Z<=(work==0)`, `C<=c_acc`, `V<=0`.
  - Next state is IDLE.
  - The register update takes effect at the DONE→IDLE edge, so `result`/flags are valid from the cycle after `done`. They hold until the next completion.
- Outside SHIFT: `sh_b=0`, `sh_a=work`. The shifter is combinational, so these values are harmless.
- Arithmetic rules:
  - The passes are logical shifts only; zeros fill from the MSB.
  - Final `C = a_in[amt_in-1]` for 1≤amt≤4, and 0 for amt=0 or amt≥5.
  - Amounts ≥4 yield `result=0`, `Z=1`.
- Pass sequence: `sh_b` takes the values 3,3,…,then the remainder. Example: amt=7 gives 3,3,1; amt=6 gives 3,3; amt=4 gives 3,1.
- `start_valid` while busy is ignored (no queuing). `a_in`/`amt_in` changes after acceptance have no effect.

## Timing
- Acceptance at edge T.
- SHIFT occupies ceil(amt/3) cycles. `done` is high in cycle T+ceil(amt/3)+1, and `result`/flags are updated at the end of that cycle.
- amt=0: `done` in cycle T+1, with no SHIFT cycle.
- Worst case amt=7: `done` in cycle T+4. The next acceptance is possible at the first IDLE cycle after `done`.
- `start_ready` is combinational from state and is 0 during SHIFT and DONE. Minimum request spacing is latency+1 cycles.
- Reset values:
  - state is IDLE and `start_ready=1` (but `start_valid` is ignored while `rst=1`).
  - `busy=0`, `done=0`, `result=0`.
  - `N=Z=C=V=0`.
  - `work=0`, `rem=0`, `c_acc=0`.
- Reset mid-operation (SHIFT or DONE): the operation is aborted. No `done` pulse, the previous result is discarded, and all outputs take their reset values at that edge.
- `start_valid` asserted in the same cycle as `done` is not accepted; the state is not IDLE.

## Test plan
- `a_in=1011`, `amt_in=1`:
  - `sh_b` sequence: 1; `done` at T+2.
  - Then `result=0101`, N=0, Z=0, C=1, V=0.
- `a_in=1011`, `amt_in=7`:
  - `sh_b` sequence: 3,3,1; `busy` for 4 cycles; `done` at T+4.
  - Then `result=0000`, Z=1, C=0.
- `a_in=1000`, `amt_in=4`:
  - `sh_b` sequence: 3,1; `done` at T+3.
  - Then `result=0000`, Z=1, C=1.
- `a_in=1000`, `amt_in=0`:
  - No SHIFT cycle; `done` at T+1.
  - Then `result=1000`, N=1, Z=0, C=0.
- Start with `amt_in=6`, hold `start_valid=1` continuously, and change `a_in` mid-operation:
  - The second request is not accepted until the IDLE cycle after `done`.
  - The first result uses the originally sampled operand.
- Start with `amt_in=7`, assert `rst` in the second SHIFT cycle:
  - No `done` pulse.
  - `result`/flags go to 0 and `start_ready=1` after reset.
  - A new request then completes normally.
